// File: rtl/locked_mult_pkg.sv
// Shared types and constants for the locked-multiplier key loader.
// State encoding, LFSR taps, default widths and the LFSR step function.
package locked_mult_pkg;

  localparam int KEY_W_DEF = 32;
  localparam int OP_W_DEF  = 8;

  // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LOAD,
    S_TEST,
    S_CHECK,
    S_UNLOCKED,
    S_LOCKOUT
  } state_t;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16_misr.sv
// 16-bit Fibonacci shift register with parallel input.
// Ports: clk_i, rst_i (sync), en_i, load_seed_i, data_i (0 = LFSR), state_o.
module lfsr16_misr
  import locked_mult_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        load_seed_i,
  input  logic [15:0] data_i,
  output logic [15:0] state_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || load_seed_i) begin
      state_o <= SEED;
    end else if (en_i) begin
      state_o <= lfsr_step(state_o) ^ data_i;
    end
  end

endmodule

// File: rtl/locked_mult_key_loader.sv
// Serial key loader and self-test unlock controller for the locked 8x8 multiplier.
// Ports: clk_i/rst_i, key_load_i/key_bit_i/key_bit_valid_i in, key_o, op1_o/op2_o,
// product_i, busy_o/unlocked_o/fail_o/lockout_o.
module locked_mult_key_loader
  import locked_mult_pkg::*;
#(
  parameter int          KEY_W      = KEY_W_DEF,
  parameter int          OP_W       = OP_W_DEF,
  parameter int          NUM_PAT    = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000,
  parameter int          MAX_RETRY  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              key_load_i,
  input  logic              key_bit_i,
  input  logic              key_bit_valid_i,
  output logic [KEY_W-1:0]  key_o,
  output logic [OP_W-1:0]   op1_o,
  output logic [OP_W-1:0]   op2_o,
  input  logic [2*OP_W-1:0] product_i,
  output logic              busy_o,
  output logic              unlocked_o,
  output logic              fail_o,
  output logic              lockout_o
);

  // Operand pair and product both map onto the 16-bit LFSR/MISR,
  // so 2*OP_W is expected to be 16.
  localparam int CW = $clog2(KEY_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(KEY_W - 1);
  localparam logic [7:0]    NP       = 8'(NUM_PAT);
  localparam logic [2:0]    RMAX     = 3'(MAX_RETRY);

  state_t state;
  state_t state_nx;

  logic [KEY_W-1:0] shadow;
  logic [KEY_W-1:0] key_q;
  logic [CW-1:0]    bit_cnt;
  logic [7:0]       tcnt;
  logic [2:0]       retry_cnt;
  logic [OP_W-1:0]  op1_q;
  logic [OP_W-1:0]  op2_q;

  logic [15:0] pat;
  logic [15:0] sig;
  logic        pat_phase;
  logic        lfsr_en;
  logic        misr_en;
  logic        reseed;
  logic        sig_ok;
  logic        last_bit;
  logic        retry_last;

  // Patterns are issued on TEST cycles 0..NUM_PAT-1; the product of
  // each one is folded into the MISR one cycle later.
  assign pat_phase  = (tcnt < NP);
  assign lfsr_en    = (state == S_TEST) && pat_phase;
  assign misr_en    = (state == S_TEST) && (tcnt != 8'd0);
  assign reseed     = (state == S_CHECK);
  assign sig_ok     = (sig == GOLDEN_SIG);
  assign last_bit   = (bit_cnt == LAST_BIT);
  assign retry_last = ((retry_cnt + 3'd1) == RMAX);

  lfsr16_misr #(
    .SEED (LFSR_SEED)
  ) u_pat (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (lfsr_en),
    .load_seed_i (reseed),
    .data_i      (16'h0000),
    .state_o     (pat)
  );

  lfsr16_misr #(
    .SEED (16'h0000)
  ) u_sig (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (misr_en),
    .load_seed_i (reseed),
    .data_i      (product_i),
    .state_o     (sig)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (key_load_i) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        if (key_bit_valid_i && last_bit) state_nx = S_LOAD;
      end
      S_LOAD: begin
        state_nx = S_TEST;
      end
      S_TEST: begin
        if (tcnt == NP) state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (sig_ok)          state_nx = S_UNLOCKED;
        else if (retry_last) state_nx = S_LOCKOUT;
        else                 state_nx = S_IDLE;
      end
      S_UNLOCKED: state_nx = S_UNLOCKED;
      S_LOCKOUT:  state_nx = S_LOCKOUT;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      shadow    <= '0;
      key_q     <= '0;
      bit_cnt   <= '0;
      tcnt      <= '0;
      retry_cnt <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          if (key_load_i) begin
            shadow  <= '0;
            bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (key_bit_valid_i) begin
            shadow  <= {shadow[KEY_W-2:0], key_bit_i};
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        S_LOAD: begin
          key_q <= shadow;
          tcnt  <= '0;
        end
        S_TEST: begin
          tcnt <= tcnt + 8'd1;
          if (pat_phase) {op1_q, op2_q} <= pat;
          else           {op1_q, op2_q} <= '0;
        end
        S_CHECK: begin
          if (!sig_ok) begin
            retry_cnt <= retry_cnt + 3'd1;
            key_q     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o     = 1'b0;
    unlocked_o = 1'b0;
    lockout_o  = 1'b0;
    fail_o     = 1'b0;
    unique case (1'b1)
      (state == S_SHIFT),
      (state == S_LOAD),
      (state == S_TEST):     busy_o = 1'b1;
      (state == S_CHECK): begin
        busy_o = 1'b1;
        fail_o = !sig_ok;
      end
      (state == S_UNLOCKED): unlocked_o = 1'b1;
      (state == S_LOCKOUT):  lockout_o = 1'b1;
      default: ;
    endcase
  end

  assign key_o = key_q;
  assign op1_o = op1_q;
  assign op2_o = op2_q;

endmodule

// File: tb/tb_locked_mult_key_loader.sv
// Bench for locked_mult_key_loader with an ideal 8x8 multiplier.
// Golden signature and expected outcomes come from a behavioural model.
module tb_locked_mult_key_loader;

  localparam int          NUM_PAT = 16;
  localparam logic [15:0] SEED    = 16'hACE1;

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] pat_k(input int k);
    logic [15:0] l;
    l = SEED;
    for (int i = 0; i < k; i++) l = step(l);
    return l;
  endfunction

  // Signature of one attempt; cidx selects a corrupted product.
  function automatic logic [15:0] calc_sig(
    input int          cidx,
    input logic [15:0] cmask
  );
    logic [15:0] l, m, p;
    l = SEED;
    m = 16'h0000;
    for (int k = 0; k < NUM_PAT; k++) begin
      p = 16'(l[15:8]) * 16'(l[7:0]);
      if (k == cidx) p = p ^ cmask;
      m = step(m) ^ p;
      l = step(l);
    end
    return m;
  endfunction

  localparam logic [15:0] GOLD = calc_sig(-1, 16'h0000);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_load = 1'b0;
  logic        key_bit = 1'b0;
  logic        key_bit_valid = 1'b0;
  logic [31:0] key;
  logic [7:0]  op1, op2;
  logic [15:0] product;
  logic        busy, unlocked, fail, lockout;

  logic        corrupt_en = 1'b0;
  logic [15:0] corrupt_pat = 16'h0;
  logic [15:0] corrupt_mask = 16'h0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    product = 16'(op1) * 16'(op2);
    if (corrupt_en && ({op1, op2} == corrupt_pat))
      product = product ^ corrupt_mask;
  end

  locked_mult_key_loader #(
    .NUM_PAT    (NUM_PAT),
    .LFSR_SEED  (SEED),
    .GOLDEN_SIG (GOLD),
    .MAX_RETRY  (3)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .key_load_i      (key_load),
    .key_bit_i       (key_bit),
    .key_bit_valid_i (key_bit_valid),
    .key_o           (key),
    .op1_o           (op1),
    .op2_o           (op2),
    .product_i       (product),
    .busy_o          (busy),
    .unlocked_o      (unlocked),
    .fail_o          (fail),
    .lockout_o       (lockout)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key_load = 1'b0;
    key_bit_valid = 1'b0;
    corrupt_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_key(
    input  logic [31:0] k,
    input  int          gap_at,
    input  int          gap_len,
    output int          p0
  );
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    p0 = cyc;
    for (int i = 31; i >= 0; i--) begin
      if (i == gap_at) begin
        key_bit_valid = 1'b0;
        repeat (gap_len) @(negedge clk);
      end
      key_bit_valid = 1'b1;
      key_bit = k[i];
      if (i == 31) p0 = cyc;
      @(negedge clk);
    end
    key_bit_valid = 1'b0;
  endtask

  task automatic wait_outcome(
    output int nfail,
    output bit done
  );
    nfail = 0;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fail) nfail++;
      if (!busy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic set_corrupt(input int idx, input int b);
    corrupt_pat = pat_k(idx);
    corrupt_mask = 16'h1 << b;
    corrupt_en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (key !== 32'h0) begin
      $display("FAIL reset_key got=%h exp=0", key);
      failures++;
    end
    checks++;
    if ({op1, op2} !== 16'h0) begin
      $display("FAIL reset_ops got=%h exp=0", {op1, op2});
      failures++;
    end
    checks++;
    if ({busy, unlocked, fail, lockout} !== 4'b0) begin
      $display("FAIL reset_flags got=%b exp=0000",
               {busy, unlocked, fail, lockout});
      failures++;
    end
  endtask

  task automatic test_shift_unlock();
    int p0;
    do_reset();
    send_key(32'h1234_5678, -1, 0, p0);
    checks++;
    if (key !== 32'h0 || busy !== 1'b1) begin
      $display("FAIL shift_key_hidden key=%h busy=%b exp=0/1", key, busy);
      failures++;
    end
    @(negedge clk);
    checks++;
    if (key !== 32'h1234_5678) begin
      $display("FAIL load_key got=%h exp=12345678", key);
      failures++;
    end
    @(negedge clk);
    checks++;
    if (op1 !== 8'hAC || op2 !== 8'hE1) begin
      $display("FAIL first_pat got=%h%h exp=ace1", op1, op2);
      failures++;
    end
    while (cyc < p0 + 50) @(negedge clk);
    checks++;
    if (unlocked !== 1'b0) begin
      $display("FAIL unlock_early got=%b exp=0", unlocked);
      failures++;
    end
    @(negedge clk);
    checks++;
    if (unlocked !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL unlock_time unl=%b busy=%b exp=1/0", unlocked, busy);
      failures++;
    end
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (unlocked !== 1'b1 || busy !== 1'b0 || key !== 32'h1234_5678) begin
      $display("FAIL unlock_hold unl=%b busy=%b key=%h exp=1/0/12345678",
               unlocked, busy, key);
      failures++;
    end
    checks++;
    if ({op1, op2} !== 16'h0) begin
      $display("FAIL unlock_ops got=%h exp=0", {op1, op2});
      failures++;
    end
  endtask

  task automatic test_bad_signature();
    int p0, nf;
    bit done;
    do_reset();
    set_corrupt(5, 0);
    send_key($urandom, -1, 0, p0);
    wait_outcome(nf, done);
    checks++;
    if (!done || nf != 1) begin
      $display("FAIL bad_sig_pulse done=%b pulses=%0d exp=1/1", done, nf);
      failures++;
    end
    checks++;
    if (key !== 32'h0 || unlocked !== 1'b0 || lockout !== 1'b0) begin
      $display("FAIL bad_sig_state key=%h unl=%b lock=%b exp=0/0/0",
               key, unlocked, lockout);
      failures++;
    end
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL bad_sig_idle busy=%b exp=1", busy);
      failures++;
    end
  endtask

  task automatic test_lockout();
    int p0, nf;
    bit done;
    do_reset();
    set_corrupt($urandom_range(0, NUM_PAT - 1), $urandom_range(0, 15));
    for (int a = 1; a <= 3; a++) begin
      send_key($urandom, -1, 0, p0);
      wait_outcome(nf, done);
      checks++;
      if (!done || nf != 1 || lockout !== (a == 3)) begin
        $display("FAIL lockout_try%0d done=%b pulses=%0d lock=%b exp=1/1/%0d",
                 a, done, nf, lockout, (a == 3));
        failures++;
      end
    end
    send_key(32'hFFFF_FFFF, -1, 0, p0);
    repeat (3) @(negedge clk);
    checks++;
    if (key !== 32'h0 || busy !== 1'b0 || lockout !== 1'b1) begin
      $display("FAIL lockout_hold key=%h busy=%b lock=%b exp=0/0/1",
               key, busy, lockout);
      failures++;
    end
  endtask

  task automatic test_reset_mid_shift();
    int p0, nf;
    bit done;
    logic [31:0] k;
    do_reset();
    set_corrupt(3, 7);
    for (int a = 0; a < 2; a++) begin
      send_key($urandom, -1, 0, p0);
      wait_outcome(nf, done);
    end
    checks++;
    if (lockout !== 1'b0 || nf != 1) begin
      $display("FAIL pre_abort lock=%b pulses=%0d exp=0/1", lockout, nf);
      failures++;
    end
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    for (int i = 0; i < 17; i++) begin
      key_bit_valid = 1'b1;
      key_bit = 1'($urandom);
      @(negedge clk);
    end
    key_bit_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({key, op1, op2, busy, unlocked, fail, lockout} !== 52'h0) begin
      $display("FAIL abort_outputs key=%h busy=%b unl=%b lock=%b exp=0",
               key, busy, unlocked, lockout);
      failures++;
    end
    rst = 1'b0;
    @(negedge clk);
    send_key($urandom, -1, 0, p0);
    wait_outcome(nf, done);
    checks++;
    if (lockout !== 1'b0 || nf != 1) begin
      $display("FAIL retry_cleared lock=%b pulses=%0d exp=0/1", lockout, nf);
      failures++;
    end
    corrupt_en = 1'b0;
    k = $urandom;
    send_key(k, -1, 0, p0);
    wait_outcome(nf, done);
    checks++;
    if (!done || unlocked !== 1'b1 || key !== k) begin
      $display("FAIL post_abort_unlock unl=%b key=%h exp=1/%h",
               unlocked, key, k);
      failures++;
    end
  endtask

  task automatic test_gap_and_stray();
    int p0, nf;
    bit done;
    logic [31:0] k;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      key_bit_valid = 1'($urandom);
      key_bit = 1'($urandom);
      @(negedge clk);
    end
    key_bit_valid = 1'b0;
    checks++;
    if (key !== 32'h0 || busy !== 1'b0) begin
      $display("FAIL stray_idle key=%h busy=%b exp=0/0", key, busy);
      failures++;
    end
    k = $urandom;
    send_key(k, $urandom_range(1, 30), 10, p0);
    @(negedge clk);
    checks++;
    if (key !== k) begin
      $display("FAIL gap_key got=%h exp=%h", key, k);
      failures++;
    end
    wait_outcome(nf, done);
    checks++;
    if (!done || unlocked !== 1'b1 || nf != 0) begin
      $display("FAIL gap_unlock done=%b unl=%b pulses=%0d exp=1/1/0",
               done, unlocked, nf);
      failures++;
    end
  endtask

  task automatic test_random();
    int p0, nf, retries, idx;
    bit done, pass, exp_lock;
    logic [15:0] mask;
    logic [31:0] k;
    do_reset();
    retries = 0;
    for (int a = 0; a < 10; a++) begin
      idx = -1;
      mask = 16'h0;
      corrupt_en = 1'b0;
      if ($urandom_range(0, 2) != 0) begin
        idx = $urandom_range(0, NUM_PAT - 1);
        mask = 16'h1 << $urandom_range(0, 15);
        set_corrupt(idx, 0);
        corrupt_mask = mask;
      end
      pass = (calc_sig(idx, mask) == GOLD);
      k = $urandom;
      send_key(k, $urandom_range(0, 40), $urandom_range(0, 5), p0);
      @(negedge clk);
      checks++;
      if (key !== k) begin
        $display("FAIL rnd%0d_key got=%h exp=%h", a, key, k);
        failures++;
      end
      wait_outcome(nf, done);
      if (!pass) retries++;
      exp_lock = (retries == 3);
      checks++;
      if (!done || unlocked !== pass || lockout !== exp_lock
          || nf != (pass ? 0 : 1)) begin
        $display("FAIL rnd%0d_outcome unl=%b lock=%b pulses=%0d exp=%b/%b/%0d",
                 a, unlocked, lockout, nf, pass, exp_lock, !pass);
        failures++;
      end
      if (pass || exp_lock) begin
        do_reset();
        retries = 0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_shift_unlock();
    test_bad_signature();
    test_lockout();
    test_reset_mid_shift();
    test_gap_and_stray();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
